// File: rtl/score_keeper.sv
// Score keeper: IDLE/PLAY/OVER game FSM with a BCD score, lives and a 4-digit multiplexed seven-segment driver.
// Defining SCORE_STREAK_BONUS_EN makes the 5th consecutive hit award 2 points.
module score_keeper #(
    parameter int LIVES    = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hit,
    input  logic        miss,
    output logic        enable,
    output logic        game_over,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int            CW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        state;
    logic          start_q;
    logic          start_edge;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    nibble;
`ifdef SCORE_STREAK_BONUS_EN
    logic [2:0]    streak;
`endif

    // Saturating BCD increment; 9999 is sticky so the score never wraps.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[d*4 +: 4] >= 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign start_edge = start & ~start_q;

    // Game FSM; miss is tested first so a simultaneous hit is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            enable    <= 1'b0;
            game_over <= 1'b0;
            score     <= 16'h0000;
            lives     <= LIVES_INIT;
            start_q   <= 1'b0;
`ifdef SCORE_STREAK_BONUS_EN
            streak    <= 3'd0;
`endif
        end else begin
            start_q <= start;
            case (state)
                IDLE, OVER: begin
                    if (start_edge) begin
                        state     <= PLAY;
                        enable    <= 1'b1;
                        game_over <= 1'b0;
                        score     <= 16'h0000;
                        lives     <= LIVES_INIT;
`ifdef SCORE_STREAK_BONUS_EN
                        streak    <= 3'd0;
`endif
                    end
                end
                PLAY: begin
                    if (miss) begin
`ifdef SCORE_STREAK_BONUS_EN
                        streak <= 3'd0;
`endif
                        if (lives <= 3'd1) begin
                            lives     <= 3'd0;
                            state     <= OVER;
                            enable    <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            lives <= lives - 3'd1;
                        end
                    end else if (hit) begin
`ifdef SCORE_STREAK_BONUS_EN
                        if (streak == 3'd4) begin
                            score  <= bcd_inc(bcd_inc(score));
                            streak <= 3'd0;
                        end else begin
                            score  <= bcd_inc(score);
                            streak <= streak + 3'd1;
                        end
`else
                        score <= bcd_inc(score);
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    enable    <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    // Display scan runs in every state, independent of the game.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        nibble = score[3:0];
        an     = 4'b1110;
        case (digit_idx)
            2'd0: begin nibble = score[3:0];   an = 4'b1110; end
            2'd1: begin nibble = score[7:4];   an = 4'b1101; end
            2'd2: begin nibble = score[11:8];  an = 4'b1011; end
            2'd3: begin nibble = score[15:12]; an = 4'b0111; end
            default: begin nibble = score[3:0]; an = 4'b1110; end
        endcase
    end

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a per-cycle vector table plus directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_score_keeper;

    localparam int LIVES    = 3;
    localparam int SCAN_DIV = 4;
`ifdef SCORE_STREAK_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hit;
    logic        miss;
    logic        enable;
    logic        game_over;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [6:0]  seg;
    logic [3:0]  an;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        start;
        logic        hit;
        logic        miss;
        logic        en;
        logic        go;
        logic [15:0] score;
        logic [2:0]  lives;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    score_keeper #(
        .LIVES   (LIVES),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hit      (hit),
        .miss     (miss),
        .enable   (enable),
        .game_over(game_over),
        .score    (score),
        .lives    (lives),
        .seg      (seg),
        .an       (an)
    );

    function automatic logic [6:0] segOf(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
            4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
            4'd8: s = 7'h00;  4'd9: s = 7'h10;  default: s = 7'h7F;
        endcase
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkState(input string name, input logic en, input logic go,
                              input logic [15:0] sc, input logic [2:0] lv);
        checkOutput({name, ".enable"},    16'(enable),    16'(en));
        checkOutput({name, ".game_over"}, 16'(game_over), 16'(go));
        checkOutput({name, ".score"},     score,          sc);
        checkOutput({name, ".lives"},     16'(lives),     16'(lv));
    endtask

    task automatic driveCycle(input logic s, input logic h, input logic m);
        start = s;
        hit   = h;
        miss  = m;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        driveCycle(v.start, v.hit, v.miss);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] exp12;
        logic [15:0] exp5;
        int          rises;
        logic        prev_en;
        int          idx, prev_idx, run_len, changes;
        int          preload;

        // Table: each record is one clock of inputs and the outputs expected right after it.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd3};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 3'd3};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 3'd3};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 3'd3};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 3'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BONUS ? 16'h0006 : 16'h0005, 3'd3};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, BONUS ? 16'h0006 : 16'h0005, 3'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BONUS ? 16'h0006 : 16'h0005, 3'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BONUS ? 16'h0007 : 16'h0006, 3'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BONUS ? 16'h0007 : 16'h0006, 3'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, BONUS ? 16'h0007 : 16'h0006, 3'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BONUS ? 16'h0007 : 16'h0006, 3'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd3};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 3'd3};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 3'd3};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 3'd3};

        exp12 = BONUS ? 16'h0014 : 16'h0012;
        exp5  = BONUS ? 16'h0006 : 16'h0005;

        start = 1'b0;
        hit   = 1'b0;
        miss  = 1'b0;
        rst   = 1'b1;
        #3 rst = 1'b0;
        #4;
        $display("[TB] checking reset values");
        checkState("reset", 1'b0, 1'b0, 16'h0000, 3'd3);
        checkOutput("reset.an",  16'(an),  16'h000E);
        checkOutput("reset.seg", 16'(seg), 16'h0040);
        #15 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] applying vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkState($sformatf("vec%0d", i), vecs[i].en, vecs[i].go, vecs[i].score, vecs[i].lives);
        end

        $display("[TB] reset mid-game with a hit pending");
        start = 1'b0;
        hit   = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkState("midreset", 1'b0, 1'b0, 16'h0000, 3'd3);
        checkOutput("midreset.an",  16'(an),  16'h000E);
        checkOutput("midreset.seg", 16'(seg), 16'h0040);
        hit = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        checkState("after_reset", 1'b0, 1'b0, 16'h0000, 3'd3);

        $display("[TB] start then 12 hits");
        driveCycle(1'b1, 1'b0, 1'b0);
        driveCycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) driveCycle(1'b0, 1'b1, 1'b0);
        driveCycle(1'b0, 1'b0, 1'b0);
        checkState("hits12", 1'b1, 1'b0, exp12, 3'd3);

        $display("[TB] display scan");
        prev_idx = -1;
        run_len  = 0;
        changes  = 0;
        for (int c = 0; c < 24; c++) begin
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                checkOutput("scan.an_onehot", 16'(an), 16'h000E);
            end else begin
                checkOutput($sformatf("scan.seg_digit%0d", idx), 16'(seg), 16'(segOf(exp12[idx*4 +: 4])));
                if (prev_idx >= 0 && idx != prev_idx) begin
                    checkOutput("scan.order", 16'(idx), 16'((prev_idx + 1) % 4));
                    if (changes > 0) checkOutput("scan.dwell", 16'(run_len), 16'(SCAN_DIV));
                    changes++;
                    run_len = 0;
                end
                prev_idx = idx;
                run_len++;
            end
            driveCycle(1'b0, 1'b0, 1'b0);
        end
        checkOutput("scan.changes_seen", 16'(changes >= 4), 16'h0001);

        $display("[TB] three misses to game over");
        driveCycle(1'b0, 1'b0, 1'b1);
        checkState("miss1", 1'b1, 1'b0, exp12, 3'd2);
        driveCycle(1'b0, 1'b0, 1'b1);
        checkState("miss2", 1'b1, 1'b0, exp12, 3'd1);
        driveCycle(1'b0, 1'b0, 1'b1);
        checkState("miss3", 1'b0, 1'b1, exp12, 3'd0);
        driveCycle(1'b0, 1'b1, 1'b0);
        driveCycle(1'b0, 1'b1, 1'b0);
        checkState("over_hits", 1'b0, 1'b1, exp12, 3'd0);

        $display("[TB] start held high for 100 cycles");
        rises   = 0;
        prev_en = enable;
        for (int c = 0; c < 100; c++) begin
            driveCycle(1'b1, 1'b0, 1'b0);
            if (enable && !prev_en) rises++;
            prev_en = enable;
        end
        checkOutput("held_start.rises", 16'(rises), 16'h0001);
        checkState("held_start", 1'b1, 1'b0, 16'h0000, 3'd3);
        driveCycle(1'b0, 1'b0, 1'b0);

        $display("[TB] five consecutive hits");
        for (int i = 0; i < 5; i++) driveCycle(1'b0, 1'b1, 1'b0);
        checkState("hits5", 1'b1, 1'b0, exp5, 3'd3);

        for (int i = 0; i < 3; i++) driveCycle(1'b0, 1'b0, 1'b1);
        checkState("over2", 1'b0, 1'b1, exp5, 3'd0);
        driveCycle(1'b1, 1'b0, 1'b0);
        driveCycle(1'b0, 1'b0, 1'b0);
        $display("[TB] four hits, miss, one hit");
        for (int i = 0; i < 4; i++) driveCycle(1'b0, 1'b1, 1'b0);
        driveCycle(1'b0, 1'b0, 1'b1);
        driveCycle(1'b0, 1'b1, 1'b0);
        checkState("streak_break", 1'b1, 1'b0, 16'h0005, 3'd2);

        driveCycle(1'b0, 1'b0, 1'b1);
        driveCycle(1'b0, 1'b0, 1'b1);
        checkState("over3", 1'b0, 1'b1, 16'h0005, 3'd0);
        driveCycle(1'b1, 1'b0, 1'b0);
        driveCycle(1'b0, 1'b0, 1'b0);

        $display("[TB] preload to 9998 then saturate");
        preload = BONUS ? 8332 : 9998;
        for (int i = 0; i < preload; i++) driveCycle(1'b0, 1'b1, 1'b0);
        driveCycle(1'b0, 1'b0, 1'b0);
        checkState("preload", 1'b1, 1'b0, 16'h9998, 3'd3);
        for (int i = 0; i < 3; i++) begin
            driveCycle(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("saturate%0d", i), score, 16'h9999);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
